// File: rtl/eh2_lsu_dc_ctl_if.sv
// CPU load/store request port and bus line port of the LSU data-cache controller.
// master = CPU/bus side, slave = cache controller.
interface eh2_lsu_dc_ctl_if #(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned LINE_W = 128
);
    logic              cpu_req_valid;
    logic              cpu_req_ready;
    logic              cpu_req_we;
    logic [1:0]        cpu_req_op;
    logic [ADDR_W-1:0] cpu_req_addr;
    logic [31:0]       cpu_req_wdata;
    logic              cpu_resp_valid;
    logic [31:0]       cpu_resp_rdata;

    logic              mem_req_valid;
    logic              mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [LINE_W-1:0] mem_req_wdata;
    logic              mem_req_ack;
    logic [LINE_W-1:0] mem_resp_rdata;

    modport master (
        output cpu_req_valid, cpu_req_we, cpu_req_op, cpu_req_addr, cpu_req_wdata,
        output mem_req_ack, mem_resp_rdata,
        input  cpu_req_ready, cpu_resp_valid, cpu_resp_rdata,
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
    );

    modport slave (
        input  cpu_req_valid, cpu_req_we, cpu_req_op, cpu_req_addr, cpu_req_wdata,
        input  mem_req_ack, mem_resp_rdata,
        output cpu_req_ready, cpu_resp_valid, cpu_resp_rdata,
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
    );
endinterface

// File: rtl/eh2_lsu_dc_ctl.sv
// Blocking write-back / write-allocate sequencer for the 4-line direct-mapped LSU data cache.
// One CPU request at a time: lookup, optional victim writeback, refill, replayed lookup, response.
module eh2_lsu_dc_ctl #(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned LINE_W = 128,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    eh2_lsu_dc_ctl_if.slave   bus,
    output logic [ADDR_W-1:0] dc_addr_tag,
    output logic [ADDR_W-1:0] dc_addr_data,
    output logic              dc_write_tag,
    output logic              dc_write_data,
    output logic [1:0]        dc_op_type_data,
    output logic [LINE_W-1:0] dc_din_tag,
    output logic [LINE_W-1:0] dc_din_data,
    input  logic [LINE_W-1:0] dc_dout_data,
    input  logic [LINE_W-1:0] dc_dout_tag,
    input  logic [ADDR_W-1:0] dc_dout_addr_tag,
    input  logic              dc_hit,
    input  logic              dc_dirty,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);
    localparam int unsigned OFF_W  = 4;
    localparam int unsigned WORD_W = 32;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {IDLE, LOOKUP, WB, REFILL, RESP} state_t;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   req_addr, req_addr_n;
    logic                req_we, req_we_n;
    logic [1:0]          req_op, req_op_n;
    logic [WORD_W-1:0]   req_wdata, req_wdata_n;
    logic                first_lkp, first_lkp_n;
    logic                resp_valid, resp_valid_n;
    logic [WORD_W-1:0]   resp_rdata, resp_rdata_n;
    logic                mem_valid, mem_valid_n;
    logic                mem_we, mem_we_n;
    logic [ADDR_W-1:0]   mem_addr, mem_addr_n;
    logic [LINE_W-1:0]   mem_wdata, mem_wdata_n;
    logic [CNT_W-1:0]    hit_cnt_n, miss_cnt_n;
    logic [ADDR_W-1:0]   line_addr;
    logic                unused_dout;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    assign line_addr        = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign unused_dout      = ^dc_dout_data[LINE_W-1:WORD_W];

    assign bus.cpu_req_ready  = (state == IDLE) && !reset;
    assign bus.cpu_resp_valid = resp_valid;
    assign bus.cpu_resp_rdata = resp_rdata;
    assign bus.mem_req_valid  = mem_valid;
    assign bus.mem_req_we     = mem_we;
    assign bus.mem_req_addr   = mem_addr;
    assign bus.mem_req_wdata  = mem_wdata;

    assign dc_addr_tag     = req_addr;
    assign dc_addr_data    = req_addr;
    assign dc_op_type_data = req_op;
    assign dc_din_tag      = bus.mem_resp_rdata;
    assign dc_din_data     = {{(LINE_W-WORD_W){1'b0}}, req_wdata};

    // Next-state, register next values and cache strobes
    always_comb begin
        state_n       = state;
        req_addr_n    = req_addr;
        req_we_n      = req_we;
        req_op_n      = req_op;
        req_wdata_n   = req_wdata;
        first_lkp_n   = first_lkp;
        resp_valid_n  = 1'b0;
        resp_rdata_n  = resp_rdata;
        mem_valid_n   = mem_valid;
        mem_we_n      = mem_we;
        mem_addr_n    = mem_addr;
        mem_wdata_n   = mem_wdata;
        hit_cnt_n     = hit_cnt;
        miss_cnt_n    = miss_cnt;
        dc_write_data = 1'b0;
        dc_write_tag  = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.cpu_req_valid) begin
                    req_addr_n  = bus.cpu_req_addr;
                    req_we_n    = bus.cpu_req_we;
                    // Reserved op encodings behave as word accesses
                    req_op_n    = bus.cpu_req_op[1] ? 2'd1 : bus.cpu_req_op;
                    req_wdata_n = bus.cpu_req_wdata;
                    first_lkp_n = 1'b1;
                    state_n     = LOOKUP;
                end
            end
            LOOKUP: begin
                first_lkp_n = 1'b0;
                if (dc_hit) begin
                    resp_valid_n  = 1'b1;
                    resp_rdata_n  = req_we ? '0 : dc_dout_data[WORD_W-1:0];
                    dc_write_data = req_we;
                    if (first_lkp) hit_cnt_n = sat_inc(hit_cnt);
                    state_n = RESP;
                end else begin
                    if (first_lkp) miss_cnt_n = sat_inc(miss_cnt);
                    mem_valid_n = 1'b1;
                    if (dc_dirty) begin
                        mem_we_n    = 1'b1;
                        mem_addr_n  = dc_dout_addr_tag;
                        mem_wdata_n = dc_dout_tag;
                        state_n     = WB;
                    end else begin
                        mem_we_n    = 1'b0;
                        mem_addr_n  = line_addr;
                        state_n     = REFILL;
                    end
                end
            end
            WB: begin
                // Writeback done: turn straight into the refill request
                if (bus.mem_req_ack) begin
                    mem_we_n   = 1'b0;
                    mem_addr_n = line_addr;
                    state_n    = REFILL;
                end
            end
            REFILL: begin
                if (bus.mem_req_ack) begin
                    dc_write_tag = 1'b1;
                    mem_valid_n  = 1'b0;
                    state_n      = LOOKUP;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (reset) begin
            dc_write_data = 1'b0;
            dc_write_tag  = 1'b0;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            req_addr   <= '0;
            req_we     <= 1'b0;
            req_op     <= '0;
            req_wdata  <= '0;
            first_lkp  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            mem_valid  <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
        end else begin
            state      <= state_n;
            req_addr   <= req_addr_n;
            req_we     <= req_we_n;
            req_op     <= req_op_n;
            req_wdata  <= req_wdata_n;
            first_lkp  <= first_lkp_n;
            resp_valid <= resp_valid_n;
            resp_rdata <= resp_rdata_n;
            mem_valid  <= mem_valid_n;
            mem_we     <= mem_we_n;
            mem_addr   <= mem_addr_n;
            mem_wdata  <= mem_wdata_n;
            hit_cnt    <= hit_cnt_n;
            miss_cnt   <= miss_cnt_n;
        end
    end
endmodule

// File: tb/tb_eh2_lsu_dc_ctl.sv
// Bench for eh2_lsu_dc_ctl: behavioural 4-line cache and line-memory models around the controller,
// expected responses and bus transactions queued at issue time and compared as the DUT produces them.
module tb_eh2_lsu_dc_ctl;
    localparam int unsigned ADDR_W = 20;
    localparam int unsigned LINE_W = 128;
    localparam int unsigned CNT_W  = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    eh2_lsu_dc_ctl_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

    logic [ADDR_W-1:0] dc_addr_tag, dc_addr_data, dc_dout_addr_tag;
    logic              dc_write_tag, dc_write_data, dc_hit, dc_dirty;
    logic [1:0]        dc_op_type_data;
    logic [LINE_W-1:0] dc_din_tag, dc_din_data, dc_dout_data, dc_dout_tag;
    logic [CNT_W-1:0]  hit_cnt, miss_cnt;

    eh2_lsu_dc_ctl #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (bus),
        .dc_addr_tag      (dc_addr_tag),
        .dc_addr_data     (dc_addr_data),
        .dc_write_tag     (dc_write_tag),
        .dc_write_data    (dc_write_data),
        .dc_op_type_data  (dc_op_type_data),
        .dc_din_tag       (dc_din_tag),
        .dc_din_data      (dc_din_data),
        .dc_dout_data     (dc_dout_data),
        .dc_dout_tag      (dc_dout_tag),
        .dc_dout_addr_tag (dc_dout_addr_tag),
        .dc_hit           (dc_hit),
        .dc_dirty         (dc_dirty),
        .hit_cnt          (hit_cnt),
        .miss_cnt         (miss_cnt)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Backing-store line contents; 0x00010 carries the DEADBEEF pattern
    function automatic logic [LINE_W-1:0] line_of(input logic [ADDR_W-1:0] a);
        if (a == 20'h00010) return {32'h55667788, 32'h11223344, 32'hDEADBEEF, 32'hDEADBEEF};
        return {32'hA0000003 ^ 32'(a), 32'hA0000002 ^ 32'(a), 32'hA0000001 ^ 32'(a), 32'hA0000000 ^ 32'(a)};
    endfunction

    // ---------------- cache array model ----------------
    logic [3:0]        c_valid = '0;
    logic [3:0]        c_dirty = '0;
    logic [13:0]       c_tag  [4];
    logic [LINE_W-1:0] c_data [4];
    logic [1:0]        t_idx;
    logic [LINE_W-1:0] d_line;

    always_comb begin
        t_idx            = dc_addr_tag[5:4];
        dc_hit           = c_valid[t_idx] && (c_tag[t_idx] == dc_addr_tag[19:6]);
        dc_dirty         = c_valid[t_idx] && c_dirty[t_idx];
        dc_dout_tag      = c_data[t_idx];
        dc_dout_addr_tag = {c_tag[t_idx], t_idx, 4'b0};
        d_line           = c_data[dc_addr_data[5:4]];
        if (dc_op_type_data == 2'd0)
            dc_dout_data = {120'b0, d_line[{dc_addr_data[3:0], 3'b0} +: 8]};
        else if (dc_op_type_data == 2'd1)
            dc_dout_data = {96'b0, d_line[{dc_addr_data[3:2], 5'b0} +: 32]};
        else
            dc_dout_data = {96'b0, 32'hBADBAD00};
    end

    always @(posedge clk) begin
        if (dc_write_data) begin
            if (dc_op_type_data == 2'd0)
                c_data[dc_addr_data[5:4]][{dc_addr_data[3:0], 3'b0} +: 8] <= dc_din_data[7:0];
            else
                c_data[dc_addr_data[5:4]][{dc_addr_data[3:2], 5'b0} +: 32] <= dc_din_data[31:0];
            c_dirty[dc_addr_data[5:4]] <= 1'b1;
        end
        if (dc_write_tag) begin
            // A line refilled over a dirty victim comes back invalid
            if (c_valid[dc_addr_tag[5:4]] && c_dirty[dc_addr_tag[5:4]]) begin
                c_valid[dc_addr_tag[5:4]] <= 1'b0;
            end else begin
                c_valid[dc_addr_tag[5:4]] <= 1'b1;
                c_tag[dc_addr_tag[5:4]]   <= dc_addr_tag[19:6];
                c_data[dc_addr_tag[5:4]]  <= dc_din_tag;
            end
            c_dirty[dc_addr_tag[5:4]] <= 1'b0;
        end
    end

    // ---------------- scoreboard queues ----------------
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] data;
    } mem_txn_t;

    logic [31:0] exp_resp_q[$];
    mem_txn_t    exp_mem_q[$];

    task automatic push_mem(input logic we, input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d);
        mem_txn_t t;
        t.we = we; t.addr = a; t.data = d;
        exp_mem_q.push_back(t);
    endtask

    // ---------------- line-memory responder ----------------
    int ack_delay = 0;
    bit ack_en    = 1'b1;
    bit late_ack  = 1'b0;
    int mem_valid_cycles = 0;

    initial begin : mem_bfm
        int       wait_n;
        mem_txn_t e;
        wait_n = 0;
        bus.mem_req_ack    = 1'b0;
        bus.mem_resp_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_req_ack    = 1'b0;
            bus.mem_resp_rdata = '0;
            if (bus.mem_req_valid) mem_valid_cycles++;
            if (late_ack) begin
                bus.mem_req_ack    = 1'b1;
                bus.mem_resp_rdata = '1;
            end else if (bus.mem_req_valid && ack_en && !reset) begin
                if (wait_n < ack_delay) wait_n++;
                else begin
                    wait_n = 0;
                    bus.mem_req_ack = 1'b1;
                    if (!bus.mem_req_we) bus.mem_resp_rdata = line_of(bus.mem_req_addr);
                    if (exp_mem_q.size() == 0) check("mem_unexpected", 128'(1), 128'(0));
                    else begin
                        e = exp_mem_q.pop_front();
                        check("mem_we", 128'(bus.mem_req_we), 128'(e.we));
                        check("mem_addr", 128'(bus.mem_req_addr), 128'(e.addr));
                        if (e.we) check("wb_data", bus.mem_req_wdata, e.data);
                    end
                end
            end else wait_n = 0;
        end
    end

    // ---------------- response / strobe monitor ----------------
    int         wd_pulses   = 0;
    logic [1:0] wd_op       = 2'd3;
    int         strobe_both = 0;

    initial begin : resp_mon
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (dc_write_tag && dc_write_data) strobe_both++;
            if (dc_write_data) begin
                wd_pulses++;
                wd_op = dc_op_type_data;
            end
            if (bus.cpu_resp_valid) begin
                if (exp_resp_q.size() == 0) check("resp_unexpected", 128'(1), 128'(0));
                else begin
                    e = exp_resp_q.pop_front();
                    check("resp_data", 128'(bus.cpu_resp_rdata), 128'(e));
                end
            end
        end
    end

    // ---------------- CPU driver ----------------
    task automatic cpu_issue(input logic we, input logic [1:0] op, input logic [ADDR_W-1:0] a,
                             input logic [31:0] wd, input logic [31:0] exp);
        int n;
        n = 0;
        @(negedge clk);
        bus.cpu_req_valid = 1'b1;
        bus.cpu_req_we    = we;
        bus.cpu_req_op    = op;
        bus.cpu_req_addr  = a;
        bus.cpu_req_wdata = wd;
        while (!bus.cpu_req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cpu_req_ready) check("req_accept_timeout", 128'(0), 128'(1));
        exp_resp_q.push_back(exp);
        @(posedge clk);
        #1;
        bus.cpu_req_valid = 1'b0;
    endtask

    // lat counts cycles from the accept cycle T; returns sampled in the response cycle
    task automatic cpu_wait_resp(output int lat);
        lat = 1;
        while (!bus.cpu_resp_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!bus.cpu_resp_valid) check("resp_timeout", 128'(0), 128'(1));
    endtask

    task automatic cpu_access(input logic we, input logic [1:0] op, input logic [ADDR_W-1:0] a,
                              input logic [31:0] wd, input logic [31:0] exp, output int lat);
        cpu_issue(we, op, a, wd, exp);
        cpu_wait_resp(lat);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        int               lat;
        int               v0;
        int               w0;
        logic [LINE_W-1:0] ln;
        logic [31:0]       w10010;

        reset             = 1'b1;
        bus.cpu_req_valid = 1'b0;
        bus.cpu_req_we    = 1'b0;
        bus.cpu_req_op    = 2'd0;
        bus.cpu_req_addr  = '0;
        bus.cpu_req_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 128'(bus.cpu_req_ready), 128'(0));
        check("rst_mem_valid", 128'(bus.mem_req_valid), 128'(0));
        check("rst_resp_valid", 128'(bus.cpu_resp_valid), 128'(0));
        check("rst_mem_addr", 128'(bus.mem_req_addr), 128'(0));
        check("rst_cnts", 128'({hit_cnt, miss_cnt}), 128'(0));
        reset = 1'b0;
        @(negedge clk);
        check("idle_ready", 128'(bus.cpu_req_ready), 128'(1));

        // Clean miss load
        push_mem(1'b0, 20'h00010, '0);
        cpu_access(1'b0, 2'd1, 20'h00010, 32'h0, 32'hDEADBEEF, lat);
        check("miss1_miss_cnt", 128'(miss_cnt), 128'(1));
        check("miss1_hit_cnt", 128'(hit_cnt), 128'(0));

        // Hit load: response at T+2, ready at T+3, no bus traffic
        v0 = mem_valid_cycles;
        cpu_access(1'b0, 2'd1, 20'h00010, 32'h0, 32'hDEADBEEF, lat);
        check("hit_latency", 128'(lat), 128'(2));
        check("hit_hit_cnt", 128'(hit_cnt), 128'(1));
        @(posedge clk);
        #1;
        check("hit_resp_pulse", 128'(bus.cpu_resp_valid), 128'(0));
        check("hit_ready_t3", 128'(bus.cpu_req_ready), 128'(1));
        check("hit_no_mem", 128'(mem_valid_cycles - v0), 128'(0));

        // Byte store then byte load
        w0 = wd_pulses;
        cpu_access(1'b1, 2'd0, 20'h00012, 32'h000000A5, 32'h0, lat);
        check("st_wd_pulses", 128'(wd_pulses - w0), 128'(1));
        check("st_wd_op", 128'(wd_op), 128'(0));
        cpu_access(1'b0, 2'd0, 20'h00012, 32'h0, 32'h000000A5, lat);

        // Conflicting load: dirty writeback then two refills
        ln = line_of(20'h00010);
        ln[23:16] = 8'hA5;
        push_mem(1'b1, 20'h00010, ln);
        push_mem(1'b0, 20'h10010, '0);
        push_mem(1'b0, 20'h10010, '0);
        ack_delay = 1;
        ln = line_of(20'h10010);
        w10010 = ln[31:0];
        cpu_access(1'b0, 2'd1, 20'h10010, 32'h0, w10010, lat);
        check("dirty_miss_cnt", 128'(miss_cnt), 128'(2));
        check("dirty_hit_cnt", 128'(hit_cnt), 128'(3));
        check("dirty_mem_q_empty", 128'(exp_mem_q.size()), 128'(0));
        ack_delay = 0;

        // Word store, then load with reserved op 3 (treated as word)
        cpu_access(1'b1, 2'd1, 20'h10014, 32'hCAFEF00D, 32'h0, lat);
        cpu_access(1'b0, 2'd3, 20'h10014, 32'h0, 32'hCAFEF00D, lat);
        check("op3_hit_cnt", 128'(hit_cnt), 128'(5));

        // Reset while a writeback is stalled
        ack_en = 1'b0;
        cpu_issue(1'b0, 2'd1, 20'h20010, 32'h0, 32'h0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("wb_hold_valid", 128'(bus.mem_req_valid), 128'(1));
        check("wb_hold_we", 128'(bus.mem_req_we), 128'(1));
        check("wb_hold_addr", 128'(bus.mem_req_addr), 128'(20'h10010));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("wbrst_mem_valid", 128'(bus.mem_req_valid), 128'(0));
        check("wbrst_ready", 128'(bus.cpu_req_ready), 128'(0));
        check("wbrst_strobes", 128'({dc_write_tag, dc_write_data}), 128'(0));
        check("wbrst_cnts", 128'({hit_cnt, miss_cnt}), 128'(0));
        reset = 1'b0;
        exp_resp_q.delete();
        exp_mem_q.delete();
        ack_en = 1'b1;
        @(negedge clk);
        check("wbrst_idle_ready", 128'(bus.cpu_req_ready), 128'(1));
        @(posedge clk);
        #1;
        late_ack = 1'b1;
        @(posedge clk);
        #1;
        late_ack = 1'b0;
        check("late_ack_ready", 128'(bus.cpu_req_ready), 128'(1));
        check("late_ack_mem_valid", 128'(bus.mem_req_valid), 128'(0));
        check("late_ack_cnts", 128'({hit_cnt, miss_cnt}), 128'(0));

        // Normal request after reset: line 0x10010 is still resident
        cpu_access(1'b0, 2'd1, 20'h10010, 32'h0, w10010, lat);
        check("post_rst_latency", 128'(lat), 128'(2));
        check("post_rst_hit_cnt", 128'(hit_cnt), 128'(1));
        check("post_rst_miss_cnt", 128'(miss_cnt), 128'(0));

        // Saturation of the hit counter
        for (int i = 0; i < 253; i++) cpu_access(1'b0, 2'd1, 20'h10010, 32'h0, w10010, lat);
        check("hit_cnt_fe", 128'(hit_cnt), 128'(8'hFE));
        for (int i = 0; i < 7; i++) cpu_access(1'b0, 2'd1, 20'h10010, 32'h0, w10010, lat);
        check("hit_cnt_sat", 128'(hit_cnt), 128'(8'hFF));
        check("sat_miss_cnt", 128'(miss_cnt), 128'(0));

        @(negedge clk);
        @(negedge clk);
        check("strobe_exclusive", 128'(strobe_both), 128'(0));
        check("resp_q_empty", 128'(exp_resp_q.size()), 128'(0));
        check("mem_q_empty", 128'(exp_mem_q.size()), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench did not complete");
    end
endmodule
